// File: rtl/cvxif_copro_router.sv
// cvxif_copro_router
//   Connects one CV-X-IF master (the core) to NrCopro coprocessors.
//   Issue requests are forked to every coprocessor. Accept and writeback
//   answers are collected, and the id of each accepted writeback
//   instruction is recorded together with its owning coprocessor.
//   Owned results are arbitrated round-robin into a one-entry registered
//   output stage towards the core. Results that no coprocessor owns
//   (orphans) are acknowledged, dropped and flagged on err_o.
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  drop all outstanding ids and the output stage
//   x_issue_*                core issue channel (instr, id in; ready, accept, writeback out)
//   copro_issue_*            per-coprocessor issue valid out; ready, accept, writeback in
//   copro_result_*           per-coprocessor result channel, packed, coprocessor 0 in the LSBs
//   x_result_*               registered result channel to the core
//   err_o                    sticky protocol error (multi-accept or orphan result)
module cvxif_copro_router #(
  parameter int unsigned NrCopro = 2,
  parameter int unsigned IdWidth = 2,
  parameter int unsigned XLEN    = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       x_issue_valid_i,
  output logic                       x_issue_ready_o,
  input  logic [31:0]                x_issue_instr_i,
  input  logic [IdWidth-1:0]         x_issue_id_i,
  output logic                       x_issue_accept_o,
  output logic                       x_issue_writeback_o,
  output logic [NrCopro-1:0]         copro_issue_valid_o,
  input  logic [NrCopro-1:0]         copro_issue_ready_i,
  input  logic [NrCopro-1:0]         copro_issue_accept_i,
  input  logic [NrCopro-1:0]         copro_issue_writeback_i,
  input  logic [NrCopro-1:0]         copro_result_valid_i,
  output logic [NrCopro-1:0]         copro_result_ready_o,
  input  logic [NrCopro*IdWidth-1:0] copro_result_id_i,
  input  logic [NrCopro*XLEN-1:0]    copro_result_data_i,
  input  logic [NrCopro*5-1:0]       copro_result_rd_i,
  input  logic [NrCopro-1:0]         copro_result_we_i,
  output logic                       x_result_valid_o,
  input  logic                       x_result_ready_i,
  output logic [IdWidth-1:0]         x_result_id_o,
  output logic [XLEN-1:0]            x_result_data_o,
  output logic [4:0]                 x_result_rd_o,
  output logic                       x_result_we_o,
  output logic                       err_o
);

  localparam int unsigned Depth = 2 ** IdWidth;
  localparam int unsigned PtrW  = (NrCopro > 1) ? $clog2(NrCopro) : 1;

  logic [Depth-1:0]   r_tbl_valid;
  logic [PtrW-1:0]    r_tbl_owner [Depth];
  logic [NrCopro-1:0] r_taken, r_acc, r_wb;
  logic [PtrW-1:0]    r_rr;
  logic               r_out_valid;
  logic [IdWidth-1:0] r_out_id;
  logic [XLEN-1:0]    r_out_data;
  logic [4:0]         r_out_rd;
  logic               r_out_we;
  logic               r_err;

  logic               w_can_issue, w_issue_done, w_multi_acc;
  logic [NrCopro-1:0] w_issue_hs, w_acc_all, w_wb_all;
  logic [PtrW-1:0]    w_owner;
  logic [IdWidth-1:0] w_res_id [NrCopro];
  logic [NrCopro-1:0] w_cand, w_orphan;
  logic               w_load_ok, w_grant_valid;
  logic [PtrW-1:0]    w_grant;
  logic               w_unused_instr;

  // The instruction word reaches the coprocessors on a shared bus; the
  // router itself never decodes it.
  assign w_unused_instr = ^x_issue_instr_i;

  // ---------------- issue fork ----------------
  assign w_can_issue         = ~flush_i & ~r_tbl_valid[x_issue_id_i];
  assign copro_issue_valid_o = {NrCopro{x_issue_valid_i & w_can_issue}} & ~r_taken;
  assign w_issue_hs          = copro_issue_valid_o & copro_issue_ready_i;
  assign w_issue_done        = x_issue_valid_i & w_can_issue & (&(r_taken | copro_issue_ready_i));
  assign w_acc_all           = r_acc | (w_issue_hs & copro_issue_accept_i);
  assign w_wb_all            = r_wb | (w_issue_hs & copro_issue_writeback_i);
  assign x_issue_ready_o     = w_issue_done;
  assign x_issue_accept_o    = w_issue_done & (|w_acc_all);
  assign x_issue_writeback_o = w_issue_done & (|w_wb_all);
  assign w_multi_acc         = w_issue_done & ($countones(w_acc_all) > 1);

  // Lowest-index accepting coprocessor owns the id (scan downwards so the
  // last assignment is the lowest index).
  always_comb begin
    w_owner = '0;
    for (int unsigned i = NrCopro; i > 0; i--) begin
      if (w_acc_all[i-1]) w_owner = PtrW'(i - 1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_taken <= '0;
      r_acc   <= '0;
      r_wb    <= '0;
    end else if (flush_i || w_issue_done) begin
      r_taken <= '0;
      r_acc   <= '0;
      r_wb    <= '0;
    end else begin
      r_taken <= r_taken | w_issue_hs;
      r_acc   <= w_acc_all;
      r_wb    <= w_wb_all;
    end
  end

  // ---------------- result arbitration ----------------
  always_comb begin
    w_cand   = '0;
    w_orphan = '0;
    for (int unsigned i = 0; i < NrCopro; i++) begin
      w_res_id[i] = copro_result_id_i[i*IdWidth +: IdWidth];
      w_cand[i]   = copro_result_valid_i[i] & r_tbl_valid[w_res_id[i]] &
                    (r_tbl_owner[w_res_id[i]] == PtrW'(i));
      w_orphan[i] = copro_result_valid_i[i] & ~w_cand[i];
    end
  end

  assign w_load_ok = ~r_out_valid | x_result_ready_i;

  always_comb begin
    logic [PtrW-1:0] idx;
    logic            found;
    idx     = '0;
    found   = 1'b0;
    w_grant = r_rr;
    for (int unsigned k = 0; k < NrCopro; k++) begin
      idx = PtrW'((32'(r_rr) + k) % NrCopro);
      if (!found && w_cand[idx]) begin
        found   = 1'b1;
        w_grant = idx;
      end
    end
    w_grant_valid = found & w_load_ok & ~flush_i;
  end

  // Orphans are acknowledged at once; during flush everything drains.
  always_comb begin
    copro_result_ready_o = w_orphan;
    if (w_grant_valid) copro_result_ready_o[w_grant] = 1'b1;
    if (flush_i) copro_result_ready_o = '1;
  end

  // ---------------- owner table ----------------
  // Set and clear never target the same id: a set needs the entry free,
  // a clear needs it valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tbl_valid <= '0;
      for (int unsigned i = 0; i < Depth; i++) r_tbl_owner[i] <= '0;
    end else if (flush_i) begin
      r_tbl_valid <= '0;
    end else begin
      if (w_grant_valid) r_tbl_valid[w_res_id[w_grant]] <= 1'b0;
      if (x_issue_accept_o && x_issue_writeback_o) begin
        r_tbl_valid[x_issue_id_i] <= 1'b1;
        r_tbl_owner[x_issue_id_i] <= w_owner;
      end
    end
  end

  // ---------------- output stage, pointer, error ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
      r_out_data  <= '0;
      r_out_rd    <= '0;
      r_out_we    <= 1'b0;
      r_rr        <= '0;
      r_err       <= 1'b0;
    end else begin
      if (flush_i) begin
        r_out_valid <= 1'b0;
      end else if (w_grant_valid) begin
        r_out_valid <= 1'b1;
        r_out_id    <= w_res_id[w_grant];
        r_out_data  <= copro_result_data_i[w_grant*XLEN +: XLEN];
        r_out_rd    <= copro_result_rd_i[w_grant*5 +: 5];
        r_out_we    <= copro_result_we_i[w_grant];
        r_rr        <= (w_grant == PtrW'(NrCopro - 1)) ? '0 : w_grant + 1'b1;
      end else if (x_result_ready_i) begin
        r_out_valid <= 1'b0;
      end
      if (w_multi_acc || ((|w_orphan) && !flush_i)) r_err <= 1'b1;
    end
  end

  assign x_result_valid_o = r_out_valid;
  assign x_result_id_o    = r_out_id;
  assign x_result_data_o  = r_out_data;
  assign x_result_rd_o    = r_out_rd;
  assign x_result_we_o    = r_out_we;
  assign err_o            = r_err;

endmodule

// File: tb/tb_cvxif_copro_router.sv
module tb_cvxif_copro_router;
  localparam int N  = 2;
  localparam int IW = 2;
  localparam int XL = 64;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          flush, iv, x_rr;
  logic [31:0]   instr;
  logic [IW-1:0] iid;
  logic [N-1:0]  c_rdy, c_acc, c_wb, r_v, r_we;
  logic [N*IW-1:0] r_id;
  logic [N*XL-1:0] r_data;
  logic [N*5-1:0]  r_rd;

  logic          irdy, iacc, iwb, xv, xwe, err;
  logic [N-1:0]  cval, crr;
  logic [IW-1:0] xid;
  logic [XL-1:0] xdata;
  logic [4:0]    xrd;

  cvxif_copro_router #(.NrCopro(N), .IdWidth(IW), .XLEN(XL)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .x_issue_valid_i(iv), .x_issue_ready_o(irdy), .x_issue_instr_i(instr),
    .x_issue_id_i(iid), .x_issue_accept_o(iacc), .x_issue_writeback_o(iwb),
    .copro_issue_valid_o(cval), .copro_issue_ready_i(c_rdy),
    .copro_issue_accept_i(c_acc), .copro_issue_writeback_i(c_wb),
    .copro_result_valid_i(r_v), .copro_result_ready_o(crr),
    .copro_result_id_i(r_id), .copro_result_data_i(r_data),
    .copro_result_rd_i(r_rd), .copro_result_we_i(r_we),
    .x_result_valid_o(xv), .x_result_ready_i(x_rr), .x_result_id_o(xid),
    .x_result_data_o(xdata), .x_result_rd_o(xrd), .x_result_we_o(xwe),
    .err_o(err)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: a set of busy ids with owners, the set of
  // coprocessors already served for the pending issue, and one held result.
  bit          m_busy [D];
  int          m_own  [D];
  bit          m_served [N];
  bit          m_said_acc [N];
  bit          m_said_wb [N];
  int          m_rr;
  bit          m_ov;
  logic [IW-1:0] m_oid;
  logic [XL-1:0] m_odata;
  logic [4:0]  m_ord;
  logic        m_owe;
  bit          m_err;

  logic [N-1:0] e_cval, e_crr;
  logic         e_irdy, e_iacc, e_iwb;
  int           e_owner, e_grant;
  bit           e_multi, e_orphan;

  function automatic void model_reset();
    for (int j = 0; j < D; j++) begin m_busy[j] = 0; m_own[j] = 0; end
    for (int i = 0; i < N; i++) begin m_served[i] = 0; m_said_acc[i] = 0; m_said_wb[i] = 0; end
    m_rr = 0; m_ov = 0; m_oid = '0; m_odata = '0; m_ord = '0; m_owe = 0; m_err = 0;
  endfunction

  function automatic void model_eval();
    bit blocked, all_in, any_wb, hs;
    bit cand [N];
    int n_acc, rid, j;
    blocked = flush || m_busy[iid];
    all_in = 1; any_wb = 0; n_acc = 0; e_owner = -1;
    for (int i = 0; i < N; i++) begin
      e_cval[i] = iv && !blocked && !m_served[i];
      if (!(m_served[i] || c_rdy[i])) all_in = 0;
      hs = e_cval[i] && c_rdy[i];
      if (m_said_acc[i] || (hs && c_acc[i])) begin
        n_acc++;
        if (e_owner < 0) e_owner = i;
      end
      if (m_said_wb[i] || (hs && c_wb[i])) any_wb = 1;
    end
    e_irdy  = iv && !blocked && all_in;
    e_iacc  = e_irdy && (n_acc > 0);
    e_iwb   = e_irdy && any_wb;
    e_multi = e_irdy && (n_acc > 1);
    e_grant = -1; e_crr = '0; e_orphan = 0;
    if (flush) begin
      e_crr = '1;
    end else begin
      for (int i = 0; i < N; i++) begin
        rid = int'(r_id[i*IW +: IW]);
        cand[i] = r_v[i] && m_busy[rid] && (m_own[rid] == i);
        if (r_v[i] && !cand[i]) begin e_crr[i] = 1; e_orphan = 1; end
      end
      if (!m_ov || x_rr) begin
        for (int k = 0; k < N; k++) begin
          j = (m_rr + k) % N;
          if (e_grant < 0 && cand[j]) e_grant = j;
        end
      end
      if (e_grant >= 0) e_crr[e_grant] = 1;
    end
  endfunction

  function automatic void model_update();
    int rid;
    if (e_multi || e_orphan) m_err = 1;
    if (e_grant >= 0) begin
      rid = int'(r_id[e_grant*IW +: IW]);
      m_busy[rid] = 0;
      m_ov = 1; m_oid = rid[IW-1:0];
      m_odata = r_data[e_grant*XL +: XL];
      m_ord = r_rd[e_grant*5 +: 5];
      m_owe = r_we[e_grant];
      m_rr = (e_grant + 1) % N;
    end else if (m_ov && x_rr) begin
      m_ov = 0;
    end
    if (e_iacc && e_iwb) begin m_busy[iid] = 1; m_own[iid] = e_owner; end
    for (int i = 0; i < N; i++) begin
      if (flush || e_irdy) begin
        m_served[i] = 0; m_said_acc[i] = 0; m_said_wb[i] = 0;
      end else if (e_cval[i] && c_rdy[i]) begin
        m_served[i] = 1;
        if (c_acc[i]) m_said_acc[i] = 1;
        if (c_wb[i]) m_said_wb[i] = 1;
      end
    end
    if (flush) begin
      for (int j = 0; j < D; j++) m_busy[j] = 0;
      m_ov = 0;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    flush = 0; iv = 0; instr = '0; iid = '0; c_rdy = '0; c_acc = '0; c_wb = '0;
    r_v = '0; r_id = '0; r_data = '0; r_rd = '0; r_we = '0; x_rr = 1;
  endtask

  task automatic set_res(input int i, input bit v, input int id, input logic [63:0] d,
                         input int rd, input bit we);
    r_v[i] = v; r_id[i*IW +: IW] = id[IW-1:0]; r_data[i*XL +: XL] = d;
    r_rd[i*5 +: 5] = rd[4:0]; r_we[i] = we;
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
    check("cycle", {cval, irdy, iacc, iwb, crr, xv, err},
                   {e_cval, e_irdy, e_iacc, e_iwb, e_crr, m_ov, m_err});
    if (m_ov) check("result", {xid, xdata, xrd, xwe}, {m_oid, m_odata, m_ord, m_owe});
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic flush_cycle();
    idle(); flush = 1; sample(); advance(); idle();
  endtask

  task automatic issue_one(input int id, input logic [1:0] who);
    idle(); iv = 1; iid = id[IW-1:0]; c_rdy = 2'b11; c_acc = who; c_wb = who;
    sample(); check("issue_one", irdy, 1'b1); advance(); idle();
  endtask

  task automatic present(input int i);
    if (i == 0) set_res(0, 1, 0, 64'hAAAA, 3, 1);
    else        set_res(1, 1, 2, 64'hBBBB, 4, 1);
  endtask

  task automatic do_reset();
    idle(); rst_n = 0; model_reset();
    @(negedge clk);
    check("reset", {cval, irdy, iacc, iwb, crr, xv, xid, xdata, xrd, xwe, err}, '0);
    @(posedge clk); #1 rst_n = 1;
  endtask

  typedef struct {
    logic iv; logic [1:0] id, rdy, acc, wb;
    logic [1:0] e_cval; logic e_rdy, e_acc, e_wb;
  } vec_t;
  vec_t tv [8];

  initial begin
    int p0, p1, g, o, pick;
    logic [1:0] prev, nprev;
    logic [IW+XL-1:0] hold;

    tv[0] = '{1'b0, 2'd0, 2'b11, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b1, 2'd1, 2'b11, 2'b10, 2'b10, 2'b11, 1'b1, 1'b1, 1'b1};
    tv[2] = '{1'b1, 2'd2, 2'b01, 2'b01, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0};
    tv[3] = '{1'b1, 2'd3, 2'b11, 2'b00, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0};
    tv[4] = '{1'b1, 2'd0, 2'b11, 2'b01, 2'b00, 2'b11, 1'b1, 1'b1, 1'b0};
    tv[5] = '{1'b1, 2'd0, 2'b00, 2'b11, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0};
    tv[6] = '{1'b1, 2'd2, 2'b11, 2'b11, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1};
    tv[7] = '{1'b1, 2'd1, 2'b10, 2'b10, 2'b10, 2'b11, 1'b0, 1'b0, 1'b0};

    do_reset();

    // A: zero-latency fork, ownership and one-cycle result latency
    flush_cycle();
    iv = 1; instr = 32'h0000_000B; iid = 1; c_rdy = 2'b11; c_acc = 2'b10; c_wb = 2'b10;
    sample(); check("A_issue", {irdy, iacc, iwb}, 3'b111); advance();
    idle(); set_res(1, 1, 1, 64'hDEAD, 5, 1);
    sample(); check("A_rready", crr, 2'b10); check("A_not_yet", xv, 1'b0); advance();
    idle(); sample(); check("A_result", {xv, xid, xdata}, {1'b1, 2'd1, 64'hDEAD}); advance();

    // B: staggered coprocessor readiness
    flush_cycle();
    iv = 1; iid = 2; c_rdy = 2'b01; c_acc = 2'b01; c_wb = 2'b01;
    sample(); check("B_c0", {cval, irdy}, 3'b110); advance();
    for (int k = 0; k < 2; k++) begin
      idle(); iv = 1; iid = 2;
      sample(); check("B_wait", {cval, irdy}, 3'b100); advance();
    end
    idle(); iv = 1; iid = 2; c_rdy = 2'b10;
    sample(); check("B_done", {cval, irdy, iacc, iwb}, 5'b10111); advance();

    // C: round-robin alternation at full throughput
    flush_cycle();
    issue_one(0, 2'b01); issue_one(1, 2'b01); issue_one(2, 2'b10); issue_one(3, 2'b10);
    p0 = 0; p1 = 0; prev = '0;
    for (int k = 0; k < 4; k++) begin
      idle();
      set_res(0, p0 < 2, p0, 64'h100 + 64'(p0), 1, 1);
      set_res(1, p1 < 2, 2 + p1, 64'h200 + 64'(p1), 2, 1);
      sample();
      check("C_onehot", $countones(crr) == 1, 1'b1);
      nprev = ~prev;
      if (k > 0) check("C_alt", crr, nprev);
      check("C_xv", xv, k > 0);
      prev = crr;
      if (crr[0]) p0++;
      if (crr[1]) p1++;
      advance();
    end
    idle(); sample(); check("C_last", xv, 1'b1); advance();

    // D: core back-pressure holds the output stage
    flush_cycle();
    issue_one(0, 2'b01); issue_one(2, 2'b10);
    idle(); x_rr = 0; present(0); present(1);
    sample(); check("D_one", $countones(crr) == 1, 1'b1); g = crr[0] ? 0 : 1; o = 1 - g; advance();
    hold = (g == 0) ? {2'd0, 64'hAAAA} : {2'd2, 64'hBBBB};
    for (int k = 0; k < 4; k++) begin
      idle(); x_rr = 0; present(o);
      sample();
      check("D_no_rdy", crr, 2'b00);
      check("D_hold", {xv, xid, xdata}, {1'b1, hold});
      advance();
    end
    idle(); present(o);
    sample(); check("D_release", {xv, crr[o]}, 2'b11); advance();
    hold = (o == 0) ? {2'd0, 64'hAAAA} : {2'd2, 64'hBBBB};
    idle(); sample(); check("D_next", {xv, xid, xdata}, {1'b1, hold}); advance();

    // E: reissue of an outstanding id stalls until it retires
    flush_cycle();
    issue_one(3, 2'b10);
    for (int k = 0; k < 2; k++) begin
      idle(); iv = 1; iid = 3; c_rdy = 2'b11; c_acc = 2'b10; c_wb = 2'b10;
      sample(); check("E_stall", {cval, irdy}, 3'b000); advance();
    end
    idle(); iv = 1; iid = 3; c_rdy = 2'b11; c_acc = 2'b10; c_wb = 2'b10;
    set_res(1, 1, 3, 64'h33, 7, 1);
    sample(); check("E_same_cycle", {irdy, crr}, 3'b010); advance();
    idle(); iv = 1; iid = 3; c_rdy = 2'b11; c_acc = 2'b10; c_wb = 2'b10;
    sample(); check("E_go", irdy, 1'b1); advance();

    // F: flush drain without error, multi-accept, orphan, sticky error
    idle(); flush = 1; set_res(0, 1, 1, 64'h1, 1, 1);
    sample(); check("F_drain", crr, 2'b11); advance();
    idle(); sample(); check("F_noerr", err, 1'b0); advance();
    idle(); iv = 1; iid = 0; c_rdy = 2'b11; c_acc = 2'b11; c_wb = 2'b11;
    sample(); check("F_multi", {irdy, iacc, iwb}, 3'b111); advance();
    idle(); sample(); check("F_err", err, 1'b1); advance();
    idle(); set_res(1, 1, 0, 64'h77, 9, 1);
    sample(); check("F_orphan", crr, 2'b10); advance();
    idle(); sample(); check("F_drop", xv, 1'b0); advance();
    flush_cycle();
    iv = 1; iid = 0; c_rdy = 2'b11;
    sample(); check("F_empty", irdy, 1'b1); check("F_sticky", err, 1'b1); advance();

    // Table: single issue cycles from a clean state
    for (int v = 0; v < 8; v++) begin
      flush_cycle();
      iv = tv[v].iv; iid = tv[v].id; c_rdy = tv[v].rdy; c_acc = tv[v].acc; c_wb = tv[v].wb;
      instr = $urandom;
      sample();
      check($sformatf("T%0d", v), {cval, irdy, iacc, iwb},
            {tv[v].e_cval, tv[v].e_rdy, tv[v].e_acc, tv[v].e_wb});
      advance();
    end

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      idle();
      flush = ($urandom_range(0, 31) == 0);
      iv    = ($urandom_range(0, 3) != 0);
      iid   = IW'($urandom_range(0, 3));
      instr = $urandom;
      c_rdy = N'($urandom_range(0, 3));
      c_acc = N'($urandom_range(0, 3));
      c_wb  = N'($urandom_range(0, 3));
      x_rr  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        pick = $urandom_range(0, 3);
        if ($urandom_range(0, 9) < 7)
          for (int j = 0; j < D; j++) if (m_busy[j] && m_own[j] == i) pick = j;
        set_res(i, $urandom_range(0, 1) == 1, pick, {$urandom, $urandom},
                $urandom_range(0, 31), $urandom_range(0, 1) == 1);
      end
      sample();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
